// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared opcodes, fetch state encoding and reset PC for the CPU.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b001010;
    localparam logic [5:0] OP_BNEQ  = 6'b001011;
    localparam logic [5:0] OP_BGEZ  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b010101;
    localparam logic [5:0] OP_JR    = 6'b010110;
    localparam logic [5:0] OP_JAL   = 6'b010111;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage
`default_nettype wire

// File: rtl/next_pc_logic.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_logic
// Brief    : Combinational next-PC selection (JR > J > taken branch > PC+4).
// Revision : 1.0
// ============================================================================
module next_pc_logic #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [25:0]       instr,
    input  logic              jump,
    input  logic              jump_reg,
    input  logic              branch,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misalign_det
);

    logic [ADDR_W-1:0] w_jump_target;
    logic [ADDR_W-1:0] w_jr_aligned;
    logic [ADDR_W-1:0] w_branch_off;
    logic [ADDR_W-1:0] w_branch_target;

    // Region bits come from PC+4, so a jump in the last slot of a 256 MB
    // region lands in the following region.
    assign w_jump_target   = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};
    assign w_jr_aligned    = {jr_target[ADDR_W-1:2], 2'b00};
    assign w_branch_off    = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
    assign w_branch_target = pc_plus4 + w_branch_off;

    always_comb begin
        next_pc = pc_plus4;
        if (jump && jump_reg) begin
            next_pc = w_jr_aligned;
        end else if (jump) begin
            next_pc = w_jump_target;
        end else if (branch && branch_taken) begin
            next_pc = w_branch_target;
        end
    end

    assign misalign_det = jump && jump_reg && (jr_target[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Req/ack instruction fetch with downstream stall and next-PC update.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic              instr_valid,
    input  logic              stall,
    input  logic              jump,
    input  logic              jump_reg,
    input  logic              branch,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              misalign
);

    localparam logic [1:0] c_st_idle = FETCH_IDLE;
    localparam logic [1:0] c_st_req  = FETCH_REQ;
    localparam logic [1:0] c_st_hold = FETCH_HOLD;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic              r_misalign;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_misalign_det;
    logic              w_consume;

    assign w_pc_plus4 = r_pc + ADDR_W'(4);
    assign w_consume  = (r_state == c_st_hold) && !stall;

    next_pc_logic #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .pc_plus4     (w_pc_plus4),
        .instr        (r_instr[25:0]),
        .jump         (jump),
        .jump_reg     (jump_reg),
        .branch       (branch),
        .branch_taken (branch_taken),
        .jr_target    (jr_target),
        .next_pc      (w_next_pc),
        .misalign_det (w_misalign_det)
    );

    // Async reset drops imem_req immediately; an ack arriving later lands in
    // IDLE and is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_pc       <= RESET_PC;
            r_instr    <= 32'h0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_state <= c_st_req;
                end
                c_st_req: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_state <= c_st_hold;
                    end
                end
                c_st_hold: begin
                    if (w_consume) begin
                        r_pc    <= w_next_pc;
                        r_state <= c_st_req;
                        if (w_misalign_det) begin
                            r_misalign <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign imem_req    = (r_state == c_st_req);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign opcode      = opcode_of(r_instr);
    assign instr_valid = (r_state == c_st_hold);
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign misalign    = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed table-driven bench for instr_fetch_unit.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic        jump_reg = 1'b0;
    logic        branch = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] start_pc;
        logic [31:0] rdata;
        logic        jump;
        logic        jump_reg;
        logic        branch;
        logic        taken;
        logic [31:0] jr_target;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[9];

    instr_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .opcode       (opcode),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .jump         (jump),
        .jump_reg     (jump_reg),
        .branch       (branch),
        .branch_taken (branch_taken),
        .jr_target    (jr_target),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assumes the DUT is in REQ; returns with the word held in HOLD.
    task automatic fetch(input logic [31:0] word);
        check("fetch_req", {31'b0, imem_req}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        check("fetch_valid", {31'b0, instr_valid}, 32'd1);
    endtask

    task automatic consume(input logic j, input logic jr, input logic b, input logic t,
                           input logic [31:0] tgt);
        jump = j; jump_reg = jr; branch = b; branch_taken = t; jr_target = tgt;
        stall = 1'b0;
        step();
        jump = 1'b0; jump_reg = 1'b0; branch = 1'b0; branch_taken = 1'b0; jr_target = 32'h0;
        stall = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0100, 32'h2822_FFFE, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_00FC};
        vecs[1] = '{32'h0000_0100, 32'h2822_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0104};
        vecs[2] = '{32'h1000_0000, 32'h5400_0040, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1000_0100};
        vecs[3] = '{32'h0000_2000, 32'h5400_0080, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0200};
        vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000};
        vecs[5] = '{32'h0000_0400, 32'h2822_0010, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0444};
        vecs[6] = '{32'h0000_0500, 32'h2822_0010, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0504};
        vecs[7] = '{32'hA000_0010, 32'h57FF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hAFFF_FFFC};
        vecs[8] = '{32'h0000_0600, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h9000, 32'h0000_0604};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req",      {31'b0, imem_req},    32'd0);
        check("rst_valid",    {31'b0, instr_valid}, 32'd0);
        check("rst_opcode",   {26'b0, opcode},      32'd0);
        check("rst_pc",       pc,                   32'h0);
        check("rst_misalign", {31'b0, misalign},    32'd0);

        // Zero-wait fetch straight out of reset.
        @(negedge clk);
        rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0800_0010; stall = 1'b0;
        #1 check("idle_req", {31'b0, imem_req}, 32'd0);
        step();
        check("c1_req",   {31'b0, imem_req},    32'd1);
        check("c1_addr",  imem_addr,            32'h0);
        check("c1_valid", {31'b0, instr_valid}, 32'd0);
        step();
        check("c2_valid", {31'b0, instr_valid}, 32'd1);
        check("c2_req",   {31'b0, imem_req},    32'd0);
        check("c2_instr", instr,                32'h0800_0010);
        check("c2_plus4", pc_plus4,             32'h4);
        step();
        check("c3_req",  {31'b0, imem_req}, 32'd1);
        check("c3_addr", imem_addr,         32'h4);
        imem_ack = 1'b0; stall = 1'b1;

        // Three wait states: address holds across all of them.
        for (int w = 0; w < 3; w++) begin
            step();
            check("wait_req",  {31'b0, imem_req}, 32'd1);
            check("wait_addr", imem_addr,         32'h4);
        end
        imem_ack = 1'b1; imem_rdata = 32'hA800_0000;
        step();
        imem_ack = 1'b0;

        // Five stall cycles, with a stray ack that must be ignored.
        for (int s = 0; s < 5; s++) begin
            if (s == 1) begin imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF; end
            else imem_ack = 1'b0;
            step();
            check("stall_pc",     pc,                 32'h4);
            check("stall_opcode", {26'b0, opcode},    32'h2A);
            check("stall_req",    {31'b0, imem_req},  32'd0);
        end
        imem_ack = 1'b0;
        check("stray_ack_instr", instr, 32'hA800_0000);
        consume(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("after_stall_addr", imem_addr, 32'h8);

        for (int i = 0; i < 9; i++) begin
            fetch(32'h0);
            consume(1'b1, 1'b1, 1'b0, 1'b0, vecs[i].start_pc);
            check($sformatf("vec%0d_start", i), imem_addr, vecs[i].start_pc);
            fetch(vecs[i].rdata);
            check($sformatf("vec%0d_opcode", i), {26'b0, opcode}, {26'b0, vecs[i].rdata[31:26]});
            consume(vecs[i].jump, vecs[i].jump_reg, vecs[i].branch, vecs[i].taken, vecs[i].jr_target);
            check($sformatf("vec%0d_next", i), imem_addr, vecs[i].exp_next);
        end
        check("no_misalign", {31'b0, misalign}, 32'd0);

        // Misaligned JR: aligned target, sticky flag, fetching continues.
        fetch(32'h5800_0000);
        consume(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0203);
        check("jr_addr",     imem_addr,          32'h200);
        check("jr_misalign", {31'b0, misalign},  32'd1);
        fetch(32'h0);
        consume(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("jr_cont_addr",     imem_addr,         32'h204);
        check("jr_misalign_hold", {31'b0, misalign}, 32'd1);

        // Reset in the middle of a request, with a late ack.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_req",      {31'b0, imem_req},  32'd0);
        check("midrst_pc",       pc,                 32'h0);
        check("midrst_misalign", {31'b0, misalign},  32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        step();
        check("midrst_instr", instr,                32'h0);
        check("midrst_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; imem_ack = 1'b0;
        step();
        check("restart_req",  {31'b0, imem_req}, 32'd1);
        check("restart_addr", imem_addr,         32'h0);
        step();
        check("restart_noack", {31'b0, instr_valid}, 32'd0);
        fetch(32'h1234_5678);
        check("restart_instr", instr, 32'h1234_5678);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Initiator end of the opcode interface: fetches 32-bit instruction words from instruction memory and presents them, with the 6-bit opcode field, to `Control_Unit`.
- Consumes the decoded `jump`/`Branch` results together with the branch condition from the ALU, and computes the next PC.
- Sits between instruction memory and the decode/execute datapath.
- Uses a req/ack memory handshake with a downstream stall, so slow instruction memory is tolerated.

## Interface
Parameters:
- `ADDR_W`, 32, PC and memory address width
- `RESET_PC`, 32'h0000_0000, PC loaded on reset

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  ADDR_W  fetch address; always equals `pc`
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle
- `imem_rdata`  in  32  instruction word
- `instr`  out  32  latched instruction
- `opcode`  out  6  `instr[31:26]`, drives `Control_Unit` `instruction`
- `instr_valid`  out  1  `instr` holds a live instruction
- `stall`  in  1  downstream holds the current instruction
- `jump`  in  1  from `Control_Unit`
- `jump_reg`  in  1  JR select (opcode 6'b010110), valid with `jump`
- `branch`  in  1  `Branch` from `Control_Unit`
- `branch_taken`  in  1  ALU branch condition result
- `jr_target`  in  ADDR_W  register operand for JR
- `pc`  out  ADDR_W  address of `instr`
- `pc_plus4`  out  ADDR_W  `pc + 4`; also the JAL link value
- `misalign`  out  1  sticky; a JR target had bits [1:0] ≠ 0

## Operation
States: IDLE, REQ, HOLD.
- **IDLE**
  - Entered only from reset.
  - Moves to REQ on the next clock.
- **REQ**
  - `imem_req`=1 and `imem_addr`=`pc`, both held stable until `imem_ack`.
  - On `imem_ack`: latch `imem_rdata` into `instr` and go to HOLD.
- **HOLD**
  - `instr_valid`=1 and `imem_req`=0.
  - `stall`=1: remain in HOLD; `instr` and `pc` are frozen.
  - `stall`=0: instruction is consumed. Load `pc` with `next_pc`, then go to REQ.

`next_pc` is evaluated on the consume cycle, first match wins:
1. `jump` & `jump_reg`: `{jr_target[ADDR_W-1:2], 2'b00}`. If `jr_target[1:0]` ≠ 0, set `misalign`.
2. `jump`: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
3. `branch` & `branch_taken`: `pc_plus4 + ({{14{instr[15]}}, instr[15:0]} << 2)`.
4. Otherwise: `pc_plus4`.

Arithmetic and boundaries:
- All address arithmetic is modulo 2^ADDR_W. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- `jump` and `branch` asserted together: jump wins.
- `branch` with `branch_taken`=0: fall through to `pc_plus4`.
- `jump`, `branch` and `jr_target` are sampled only on the consume cycle; they are ignored in IDLE and REQ.
- `imem_ack` outside REQ is ignored.
- `misalign` clears only on reset and does not stop fetching.

## Timing
Reset values (async assert, applies immediately mid-request):
- `pc`=RESET_PC
- state=IDLE
- `imem_req`=0
- `instr_valid`=0
- `instr`=0, so `opcode`=000000
- `misalign`=0

After reset:
- First `imem_req` is asserted in the 2nd rising edge after `rst_n` deasserts (IDLE→REQ).
- An in-flight request is abandoned on reset; a late `imem_ack` is ignored.

Latencies and throughput:
- Ack to `instr_valid`: 1 cycle (registered).
- Consume to next `imem_req`: 1 cycle.
- Zero wait states: one instruction per 2 cycles (REQ, HOLD).
- N wait states: one instruction per N+2 cycles.

Output relationships:
- `opcode`, `pc`, `pc_plus4` are stable for the whole HOLD period.
- `pc_plus4` is combinational from `pc`.

## Structure
Shared package `cpu_pkg` holds:
- Opcode constants: `OP_RTYPE`=000000, `OP_BEQ`=001010, `OP_BNEQ`=001011, `OP_BGEZ`=001100, `OP_J`=010101, `OP_JR`=010110, `OP_JAL`=010111.
- The fetch state enum.
- The default `RESET_PC`.

One combinational sub-module, `next_pc_logic`:
- Inputs: `pc_plus4`, `instr`, control inputs, `jr_target`.
- Outputs: `next_pc`, `misalign_det`.
- The FSM and the PC/instruction registers stay in the top module.

## Test plan
- **Reset then zero-wait fetch**: release `rst_n`, tie `imem_ack`=1 → `imem_req` on cycle 2 at addr 0, `instr_valid` on cycle 3, next request at addr 4 on cycle 4.
- **Wait states and stall**:
  - 3 wait states → `imem_addr` stable for 4 cycles.
  - `stall`=1 for 5 cycles in HOLD → `pc` and `opcode` unchanged, no request issued.
- **Taken BEQ**: at pc 0x100, offset 0xFFFE → next fetch at 0x0FC.
- **Untaken BEQ**: same instruction with `branch_taken`=0 → next fetch at 0x104.
- **J and JR**:
  - J at pc 0x1000_0000, `instr[25:0]`=0x40 → next fetch at 0x1000_0100.
  - JR with `jr_target`=0x203 → fetch 0x200 and `misalign`=1, which persists.
- **Priority and reset mid-request**:
  - `jump`=1 with `branch`=`branch_taken`=1 → jump target used.
  - `rst_n` low during REQ → `imem_req` drops at once; after release, fetch restarts at RESET_PC.
